// File: rtl/nibble_serial_add.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_add
// Purpose  : Performs a wide addition through one external 4-bit adder,
//            one nibble per clock, low nibble first. Operands and carry-in
//            are latched when start is accepted. The running carry is fed
//            back to the adder and the sum nibbles are collected into the
//            wide result.
// Ports    : clk, rst            - clock (rising edge), async active-high reset
//            start, op_a, op_b,
//            cin                 - request and operands, sampled in IDLE only
//            busy, done          - status; done is a one-cycle result strobe
//            result, cout        - wide sum and final carry, held until next start
//            add_a, add_b,
//            add_cin             - drive to the external adder (0 outside RUN)
//            add_sum, add_cout   - combinational answer from the external adder
// Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_add #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   cin,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_sum,
  input  logic                   add_cout
);

  localparam int W  = 4 * NIBBLES;
  // Index width; a single-nibble build still needs a 1-bit index register.
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] C_LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   idx_q;
  logic            carry_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    result_q;
  logic [W-1:0]    result_d;
  logic            cout_q;
  logic            busy_q;
  logic            done_q;
  logic [3:0]      a_nib;
  logic [3:0]      b_nib;

  // Nibble select of the latched operands and merge of the adder's sum
  // into the matching slot of the result register. Constant part-selects
  // keep the mux free of variable-width index arithmetic.
  always_comb begin
    a_nib    = 4'd0;
    b_nib    = 4'd0;
    result_d = result_q;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx_q == IW'(n)) begin
        a_nib               = a_q[4*n +: 4];
        b_nib               = b_q[4*n +: 4];
        result_d[4*n +: 4]  = add_sum;
      end
    end
  end

  // Adder drive is forced to zero outside RUN so the external adder sees
  // a quiet input whenever no nibble is in flight.
  always_comb begin
    add_a   = 4'd0;
    add_b   = 4'd0;
    add_cin = 1'b0;
    if (state_q == S_RUN) begin
      add_a   = a_nib;
      add_b   = b_nib;
      add_cin = carry_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q  <= S_RUN;
            a_q      <= op_a;
            b_q      <= op_b;
            carry_q  <= cin;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        S_RUN: begin
          result_q <= result_d;
          carry_q  <= add_cout;
          if (idx_q == C_LAST_IDX) begin
            // Index holds at the top nibble; it returns to 0 on DONE->IDLE.
            cout_q  <= add_cout;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          idx_q   <= '0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_add.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_add
// Purpose  : Scoreboard bench for nibble_serial_add (NIBBLES=4) with a 4-bit
//            ripple adder model on the add_* ports. Stimulus pushes expected
//            {cout,result}; a monitor pops on every done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_add;

  localparam int NIB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        cin = 1'b0;
  logic        busy, done, cout;
  logic [15:0] result;
  logic [3:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [16:0] exp_q[$];
  int          done_cyc[$];

  always #5 clk = ~clk;

  // External 4-bit adder.
  assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  nibble_serial_add #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
    .busy(busy), .done(done), .result(result), .cout(cout),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (!busy || done)
      check("add_idle_zero", {23'd0, add_a, add_b, add_cin}, 32'd0);
    if (done) begin
      done_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        check("result", {15'd0, cout, result}, {15'd0, e});
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  // Waits for IDLE, presents one request, returns #1 after the accepting edge
  // with operands scrambled so only the latched copies can matter.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic c,
                       input logic [15:0] er, input logic ec);
    wait_idle();
    op_a = a; op_b = b; cin = c; start = 1'b1;
    exp_q.push_back({ec, er});
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a = 16'($urandom); op_b = 16'($urandom); cin = 1'($urandom);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_state", {11'd0, busy, done, cout, result}, 32'd0);
    check("rst_add", {23'd0, add_a, add_b, add_cin}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: 1234 + 0FFF
    begin
      int bcnt = 0, dat = 0, k = 0;
      issue(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0);
      for (k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (busy) bcnt++;
        if (done) dat = k;
      end
      check("t1_busy_cycles", 32'(bcnt), 32'd5);
      check("t1_done_cycle", 32'(dat), 32'd5);
    end

    // 2: FFFF + 0001, carry ripples through nibbles 1..3
    begin
      logic [3:0] cins;
      issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        cins[k] = add_cin;
      end
      check("t2_add_cin", {28'd0, cins}, 32'h0000_000E);
    end

    // 3: carry-in edge cases
    issue(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0);
    issue(16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1);
    issue(16'h00F0, 16'h0F10, 1'b0, 16'h1000, 1'b0);
    wait_idle();

    // 4: start held high; operands churn while busy
    wait_idle();
    done_cyc.delete();
    for (int k = 0; k < 13; k++) begin
      if (k > 0) @(negedge clk);
      if (!busy) begin
        op_a = 16'h0001; op_b = 16'h0001; cin = 1'b0;
        exp_q.push_back({1'b0, 16'h0002});
      end else begin
        op_a = 16'($urandom); op_b = 16'($urandom); cin = 1'($urandom);
      end
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    check("t4_done_count", 32'(done_cyc.size()), 32'd3);
    if (done_cyc.size() == 3) begin
      check("t4_spacing_a", 32'(done_cyc[1] - done_cyc[0]), 32'd6);
      check("t4_spacing_b", 32'(done_cyc[2] - done_cyc[1]), 32'd6);
    end

    // 5: async reset after RUN cycle 2
    issue(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    exp_q.delete();
    rst = 1'b1;
    #1;
    check("t5_abort", {11'd0, busy, done, cout, result}, 32'd0);
    check("t5_abort_add", {23'd0, add_a, add_b, add_cin}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    issue(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0);
    wait_idle();
    check("t5_result_hold", {15'd0, cout, result}, 32'h0000_2345);

    // 6: sweep against a W+1 bit reference sum
    for (int v = 0; v < 1000; v++) begin
      logic [15:0] a, b;
      logic        c;
      logic [16:0] s;
      a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
      s = 17'(a) + 17'(b) + 17'(c);
      issue(a, b, c, s[15:0], s[16]);
    end

    // Drain
    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("drain", 32'(exp_q.size()), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
